sha_256_compress: RTL and testbench
===================================

// Module: sha_256_compress
// PURPOSE
//  Iterative SHA-256 compression engine, the consumer of the 64-word message schedule.
//  Reads W[0..63] from sha_256_schedular and runs the 64 compression rounds over working
//  variables a..h. Adds the result into the chaining state H0..H7 and presents the digest.
//  Sits between the block padder/scheduler and the hash output register; chains multi-block messages.
// PARAMETERS
//  UNROLL  1  rounds computed per clock; legal values are 1, 2 and 4 (other values rejected at elaboration)
// PORTS
//  i_clk      in   1        single clock, all flops on rising edge
//  i_rst      in   1        asynchronous, active-high reset
//  i_start    in   1        request: compress the block whose schedule is on i_w
//  i_init     in   1        sampled with accepted i_start; 1 = first block (load IV), 0 = chain from H
//  i_sch_done in   1        schedule valid qualifier from scheduler
//  i_w        in   32x64    unpacked [31:0] i_w[63:0]; i_w[t] = W_t
//  o_ready    out  1        1 in IDLE only; i_start accepted only when o_ready=1
//  o_busy     out  1        1 in ROUND and FINAL
//  o_done     out  1        one-cycle pulse; o_hash updated for this block
//  o_hash     out  256      {H0,H1,...,H7}, H0 in [255:224]
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, t=0, a..h=0, H0..H7=IV (6a09e667 bb67ae85 3c6ef372
//   a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), o_ready=1, o_busy=0, o_done=0, o_hash=IV.
//  FSM IDLE -> ROUND -> FINAL -> IDLE.
//  IDLE: edge with i_start=1 and i_sch_done=1 is accepted.
//   - Working vars a..h load IV if i_init=1, else current H0..H7.
//   - i_init=1 also loads IV into H; t=0; go to ROUND.
//   - i_start with i_sch_done=0 is ignored, with no state change.
//  ROUND: each edge applies UNROLL rounds t..t+UNROLL-1, then t += UNROLL.
//   - Per round: T1 = h + S1(e) + Ch(e,f,g) + K[t] + i_w[t].
//   - T2 = S0(a) + Maj(a,b,c).
//   - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
//   - S0 = ror2^ror13^ror22; S1 = ror6^ror11^ror25.
//   - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
//   - K[0..63] are FIPS 180-4 constants held in internal ROM.
//   - Edge applying round 63 moves to FINAL.
//  FINAL: one edge; Hi += working var i for i=0..7 (a->H0 ... h->H7), all modulo 2^32.
//   - o_done=1 for exactly the following cycle; FSM returns to IDLE.
//  All adds are 32-bit, carries discarded; no other width growth.
//  Latency: accept edge E0; rounds on E1..E(64/UNROLL); FINAL on E(64/UNROLL+1).
//   - o_done high in the cycle after that edge: 65 clocks for UNROLL=1, 33 for UNROLL=2.
//  o_ready rises together with o_done; a new i_start is accepted in that same cycle (back-to-back).
//  i_start while o_ready=0 is ignored (no queueing).
//  i_w and i_init must be held stable from acceptance until o_done; the block does not latch i_w.
//  Changes to i_w or i_init in that window are not detected; the digest is then undefined.
//  i_sch_done is checked only at acceptance; mid-block deassertion has no effect.
//  o_hash is stable except at the FINAL edge and reset; it is valid from o_done until the next FINAL.
//  Reset mid-operation aborts the block: the partial result is never added to H, o_done does not pulse.
// TESTING
//  1 Single block "abc" (padded 61626380 00..00 00000018 into scheduler), i_init=1, UNROLL=1:
//     o_done exactly 65 clocks after accept.
//     o_hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
//  2 Empty message (80000000 00..00), i_init=1:
//     o_hash = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  3 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq".
//     Block 1 with i_init=1; block 2 back-to-back in the o_done cycle with i_init=0.
//     Final o_hash = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  4 Assert i_rst at round 30 of "abc": o_busy=0, o_ready=1 and o_hash=IV immediately.
//     No o_done pulse; rerun "abc" -> digest from test 1.
//  5 Ignored requests: i_start at round 10 -> no effect, single o_done, digest unchanged.
//     i_start with i_sch_done=0 in IDLE -> o_ready stays 1, o_busy stays 0.
//  6 UNROLL=2 and UNROLL=4 builds on tests 1 and 3: same digests.
//     o_done 33 and 17 clocks after accept respectively.

Source files
------------

// File: rtl/sha_256_compress.sv
// Iterative SHA-256 compression engine: consumes a 64-word schedule, runs UNROLL rounds
// per clock over a..h, then folds the working variables into the chaining state H0..H7.
module sha_256_compress #(
    parameter int UNROLL = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_init,
    input  logic          i_sch_done,
    input  logic [31:0]   i_w [63:0],
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic [255:0]  o_hash
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
            $error("sha_256_compress: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  t_q;
    logic [31:0] work_q [0:7];
    logic [31:0] work_d [0:7];
    logic [31:0] h_q [0:7];
    logic [31:0] t1, t2;
    logic [5:0]  idx;
    logic        done_q;
    logic        accept;
    logic        last_step;

    assign accept    = (state_q == IDLE) && i_start && i_sch_done;
    assign last_step = (t_q == 6'(64 - UNROLL));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FINAL);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ROUND;
            ROUND:   if (last_step) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // UNROLL rounds chained combinationally; each stage feeds the next with t advanced by one
    always_comb begin
        for (int i = 0; i < 8; i++) work_d[i] = work_q[i];
        t1  = '0;
        t2  = '0;
        idx = '0;
        for (int u = 0; u < UNROLL; u++) begin
            idx = t_q + 6'(u);
            t1  = work_d[7] + big_s1(work_d[4]) + ((work_d[4] & work_d[5]) ^ (~work_d[4] & work_d[6]))
                  + K[idx] + i_w[idx];
            t2  = big_s0(work_d[0]) + ((work_d[0] & work_d[1]) ^ (work_d[0] & work_d[2]) ^ (work_d[1] & work_d[2]));
            work_d[7] = work_d[6];
            work_d[6] = work_d[5];
            work_d[5] = work_d[4];
            work_d[4] = work_d[3] + t1;
            work_d[3] = work_d[2];
            work_d[2] = work_d[1];
            work_d[1] = work_d[0];
            work_d[0] = t1 + t2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            t_q <= '0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                h_q[i]    <= IV[i];
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        t_q <= '0;
                        for (int i = 0; i < 8; i++) begin
                            work_q[i] <= i_init ? IV[i] : h_q[i];
                            if (i_init) h_q[i] <= IV[i];
                        end
                    end
                end
                ROUND: begin
                    t_q <= t_q + 6'(UNROLL);
                    for (int i = 0; i < 8; i++) work_q[i] <= work_d[i];
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + work_q[i];
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q == ROUND) || (state_q == FINAL);
    assign o_done  = done_q;
    assign o_hash  = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha_256_compress.sv
// Directed bench for sha_256_compress: three instances (UNROLL 1/2/4) fed from one
// bench-side message schedule, checked against known SHA-256 digests and latencies.
module tb_sha_256_compress;

    localparam logic [255:0] IV_HASH    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_HASH   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_HASH = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_HASH   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {448'h0, 32'h00000000, 32'h000001c0};

    logic         clk;
    logic         rst;
    logic         start_s    [3];
    logic         init_s     [3];
    logic         sch_s      [3];
    logic         ready_s    [3];
    logic         busy_s     [3];
    logic         done_s     [3];
    logic [255:0] hash_s     [3];
    logic [31:0]  w_arr      [63:0];
    int           unroll_of  [3] = '{1, 2, 4};

    int vectors;
    int miscompares;

    sha_256_compress #(.UNROLL(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[0]), .i_init(init_s[0]), .i_sch_done(sch_s[0]),
        .i_w(w_arr), .o_ready(ready_s[0]), .o_busy(busy_s[0]), .o_done(done_s[0]), .o_hash(hash_s[0]));

    sha_256_compress #(.UNROLL(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[1]), .i_init(init_s[1]), .i_sch_done(sch_s[1]),
        .i_w(w_arr), .o_ready(ready_s[1]), .o_busy(busy_s[1]), .o_done(done_s[1]), .o_hash(hash_s[1]));

    sha_256_compress #(.UNROLL(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[2]), .i_init(init_s[2]), .i_sch_done(sch_s[2]),
        .i_w(w_arr), .o_ready(ready_s[2]), .o_busy(busy_s[2]), .o_done(done_s[2]), .o_hash(hash_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference message schedule expansion so the engine sees real W[0..63]
    task automatic load_block(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w_arr[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w_arr[t-15], 7) ^ ror(w_arr[t-15], 18) ^ (w_arr[t-15] >> 3);
            s1 = ror(w_arr[t-2], 17) ^ ror(w_arr[t-2], 19) ^ (w_arr[t-2] >> 10);
            w_arr[t] = w_arr[t-16] + s0 + w_arr[t-7] + s1;
        end
    endtask

    task automatic launch(input int idx, input logic init_v);
        start_s[idx] = 1'b1;
        init_s[idx]  = init_v;
        sch_s[idx]   = 1'b1;
        @(negedge clk);
        start_s[idx] = 1'b0;
        sch_s[idx]   = 1'b0;
    endtask

    task automatic wait_done(input int idx, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 200) begin
            if (done_s[idx]) seen = 1'b1;
            else begin
                @(negedge clk);
                cycles++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ready_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || done_s[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_flags dut%0d: ready=%b busy=%b done=%b, want 1 0 0", i, ready_s[i], busy_s[i], done_s[i]);
            end
            vectors++;
            if (hash_s[i] !== IV_HASH) begin
                miscompares++;
                $display("[TB] FAIL reset_hash dut%0d: got %h want %h", i, hash_s[i], IV_HASH);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input int idx, input logic [511:0] blk, input logic [255:0] exp, input string name);
        int cycles;
        bit seen;
        int lat;
        lat = 64 / unroll_of[idx] + 1;
        load_block(blk);
        launch(idx, 1'b1);
        vectors++;
        if (busy_s[idx] !== 1'b1 || ready_s[idx] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_busy dut%0d: busy=%b ready=%b, want 1 0", name, idx, busy_s[idx], ready_s[idx]);
        end
        wait_done(idx, cycles, seen);
        vectors++;
        if (!seen || cycles != lat) begin
            miscompares++;
            $display("[TB] FAIL %s_latency dut%0d: seen=%b cycles=%0d, want 1 %0d", name, idx, seen, cycles, lat);
        end
        vectors++;
        if (hash_s[idx] !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s_digest dut%0d: got %h want %h", name, idx, hash_s[idx], exp);
        end
        @(negedge clk);
        vectors++;
        if (done_s[idx] !== 1'b0 || ready_s[idx] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_pulse dut%0d: done=%b ready=%b, want 0 1", name, idx, done_s[idx], ready_s[idx]);
        end
    endtask

    task automatic test_back_to_back(input int idx);
        int cycles;
        bit seen;
        int lat;
        lat = 64 / unroll_of[idx] + 1;
        load_block(TWO_BLK1);
        launch(idx, 1'b1);
        wait_done(idx, cycles, seen);
        vectors++;
        if (!seen || ready_s[idx] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_blk1_done dut%0d: seen=%b ready=%b, want 1 1", idx, seen, ready_s[idx]);
        end
        load_block(TWO_BLK2);
        launch(idx, 1'b0);
        vectors++;
        if (done_s[idx] !== 1'b0 || busy_s[idx] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept dut%0d: done=%b busy=%b, want 0 1", idx, done_s[idx], busy_s[idx]);
        end
        wait_done(idx, cycles, seen);
        vectors++;
        if (!seen || cycles != lat) begin
            miscompares++;
            $display("[TB] FAIL b2b_latency dut%0d: seen=%b cycles=%0d, want 1 %0d", idx, seen, cycles, lat);
        end
        vectors++;
        if (hash_s[idx] !== TWO_HASH) begin
            miscompares++;
            $display("[TB] FAIL b2b_digest dut%0d: got %h want %h", idx, hash_s[idx], TWO_HASH);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int pulses;
        load_block(ABC_BLK);
        launch(0, 1'b1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (busy_s[0] !== 1'b0 || ready_s[0] !== 1'b1 || hash_s[0] !== IV_HASH) begin
            miscompares++;
            $display("[TB] FAIL midreset_state: busy=%b ready=%b hash=%h, want 0 1 %h", busy_s[0], ready_s[0], hash_s[0], IV_HASH);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_s[0]) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_no_done: got %0d pulses, want 0", pulses);
        end
        test_single(0, ABC_BLK, ABC_HASH, "rerun_abc");
    endtask

    task automatic test_ignored();
        int cycles;
        bit seen;
        int pulses;
        load_block(ABC_BLK);
        launch(0, 1'b1);
        repeat (10) @(negedge clk);
        launch(0, 1'b1);
        wait_done(0, cycles, seen);
        vectors++;
        if (!seen || cycles + 11 != 65) begin
            miscompares++;
            $display("[TB] FAIL ignored_latency: seen=%b cycles=%0d, want 1 65", seen, cycles + 11);
        end
        vectors++;
        if (hash_s[0] !== ABC_HASH) begin
            miscompares++;
            $display("[TB] FAIL ignored_digest: got %h want %h", hash_s[0], ABC_HASH);
        end
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_s[0]) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("[TB] FAIL ignored_extra_done: got %0d pulses, want 0", pulses);
        end
        start_s[0] = 1'b1;
        init_s[0]  = 1'b1;
        sch_s[0]   = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        vectors++;
        if (ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nosched_flags: ready=%b busy=%b, want 1 0", ready_s[0], busy_s[0]);
        end
        pulses = 0;
        repeat (70) begin
            @(negedge clk);
            if (done_s[0]) pulses++;
        end
        vectors++;
        if (pulses != 0 || hash_s[0] !== ABC_HASH) begin
            miscompares++;
            $display("[TB] FAIL nosched_quiet: pulses=%0d hash=%h, want 0 %h", pulses, hash_s[0], ABC_HASH);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            init_s[i]  = 1'b0;
            sch_s[i]   = 1'b0;
        end
        for (int t = 0; t < 64; t++) w_arr[t] = '0;

        test_reset();
        test_single(0, ABC_BLK, ABC_HASH, "abc");
        test_single(0, EMPTY_BLK, EMPTY_HASH, "empty");
        test_back_to_back(0);
        test_reset_mid();
        test_ignored();
        test_single(1, ABC_BLK, ABC_HASH, "abc_u2");
        test_back_to_back(1);
        test_single(2, ABC_BLK, ABC_HASH, "abc_u4");
        test_back_to_back(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
